// File: rtl/inst_buffer_pkg.sv
// -----------------------------------------------------------------------------
// inst_buffer_pkg
// Shared definitions for the fetch-to-decode instruction buffer.
//   DEFAULT_WORD_SIZE : default instruction word width
//   DEFAULT_DEPTH     : default number of buffer entries
//   NOP_FILL          : bit value replicated to form the NOP encoding
//   NOP_INST          : NOP encoding at the default width (all ones, unused
//                       by the ISA)
// -----------------------------------------------------------------------------
package inst_buffer_pkg;

    localparam int DEFAULT_WORD_SIZE = 16;
    localparam int DEFAULT_DEPTH     = 4;

    // The NOP is all ones at any width; users build it as {W{NOP_FILL}}.
    localparam logic                         NOP_FILL = 1'b1;
    localparam logic [DEFAULT_WORD_SIZE-1:0] NOP_INST = {DEFAULT_WORD_SIZE{NOP_FILL}};

endpackage : inst_buffer_pkg

// File: rtl/inst_buffer_if.sv
// -----------------------------------------------------------------------------
// inst_buffer_if
// Handshake bundle between fetch, the instruction buffer and decode.
//   flush      : discard all buffered entries (highest priority)
//   push_valid : fetch offers push_inst
//   push_inst  : instruction word from fetch
//   push_ready : buffer can accept a word
//   pop_valid  : inst holds a valid instruction
//   pop_ready  : decode consumes inst this cycle
//   inst       : head instruction, or NOP when not valid
//   count      : number of stored entries
// Modports: master = fetch/decode environment, slave = the buffer.
// -----------------------------------------------------------------------------
interface inst_buffer_if
    import inst_buffer_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int DEPTH     = DEFAULT_DEPTH
);

    logic                         flush;
    logic                         push_valid;
    logic [WORD_SIZE-1:0]         push_inst;
    logic                         push_ready;
    logic                         pop_valid;
    logic                         pop_ready;
    logic [WORD_SIZE-1:0]         inst;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output flush, push_valid, push_inst, pop_ready,
        input  push_ready, pop_valid, inst, count
    );

    modport slave (
        input  flush, push_valid, push_inst, pop_ready,
        output push_ready, pop_valid, inst, count
    );

endinterface : inst_buffer_if

// File: rtl/inst_buffer_mem.sv
// -----------------------------------------------------------------------------
// inst_buffer_mem
// DEPTH x WORD_SIZE register array, one synchronous write port and one
// asynchronous read port.
//   clk     : write clock
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : combinational read data
// -----------------------------------------------------------------------------
module inst_buffer_mem #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 4,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [PTR_W-1:0]     wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic [PTR_W-1:0]     rd_addr,
    output logic [WORD_SIZE-1:0] rd_data
);

    logic [WORD_SIZE-1:0] mem [DEPTH];

    // NOTE: storage has no reset; entries are only read once the pointers
    // say they were written, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule : inst_buffer_mem

// File: rtl/inst_buffer.sv
// -----------------------------------------------------------------------------
// inst_buffer
// FIFO instruction buffer between fetch and decode with valid/ready
// handshakes on both sides and a flush that empties it and presents NOP.
//   clk     : clock, all state changes on posedge
//   reset_n : asynchronous active-low reset (pointers and count clear)
//   bus     : inst_buffer_if.slave handshake bundle (see inst_buffer_if)
// Optional feature macro: INST_BUFFER_BYPASS_EN
//   When defined, a word offered to an empty buffer appears on inst in the
//   same cycle; if decode takes it, it is never stored.
//   When undefined, minimum push-to-inst latency is one cycle.
// -----------------------------------------------------------------------------
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int DEPTH     = DEFAULT_DEPTH
) (
    input  logic         clk,
    input  logic         reset_n,
    inst_buffer_if.slave bus
);

    localparam int                   PTR_W      = $clog2(DEPTH);
    localparam int                   CNT_W      = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]     FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [WORD_SIZE-1:0] NOP        = {WORD_SIZE{NOP_FILL}};

    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count_q;
    logic [WORD_SIZE-1:0] head;

    logic                 empty;
    logic                 push_ready_int;
    logic                 pop_valid_int;
    logic                 bypass_hit;
    logic                 push_store;
    logic                 pop_store;
    logic [WORD_SIZE-1:0] inst_int;

    inst_buffer_mem #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_store),
        .wr_addr (wr_ptr),
        .wr_data (bus.push_inst),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    assign empty = (count_q == '0);

    // Full means full: a pop in the same cycle does not open a slot.
    assign push_ready_int = (count_q != FULL_COUNT);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        bypass_hit    = 1'b0;
        pop_valid_int = !empty && !bus.flush;
        inst_int      = NOP;

`ifdef INST_BUFFER_BYPASS_EN
        if (empty && bus.push_valid && !bus.flush) begin
            bypass_hit    = 1'b1;
            pop_valid_int = 1'b1;
        end
`endif

        if (bypass_hit) begin
            inst_int = bus.push_inst;
        end else if (pop_valid_int) begin
            inst_int = head;
        end

        // A bypassed word taken by decode is consumed without being stored.
        push_store = bus.push_valid && push_ready_int && !bus.flush
                     && !(bypass_hit && bus.pop_ready);
        // Pops only retire stored entries; a bypass hit leaves rd_ptr alone.
        pop_store  = pop_valid_int && bus.pop_ready && !empty;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_store) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_store, pop_store})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.push_ready = push_ready_int;
    assign bus.pop_valid  = pop_valid_int;
    assign bus.inst       = inst_int;
    assign bus.count      = count_q;

endmodule : inst_buffer

// File: tb/tb_inst_buffer.sv
// -----------------------------------------------------------------------------
// tb_inst_buffer
// Directed self-checking bench for inst_buffer (WORD_SIZE=16, DEPTH=4).
// Expectations follow INST_BUFFER_BYPASS_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_inst_buffer;

    localparam int WORD_SIZE = 16;
    localparam int DEPTH     = 4;

    logic clk;
    logic reset_n;

    int checks;
    int errors;

    inst_buffer_if #(.WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH)) bus ();

    inst_buffer #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic pv, input logic [15:0] ins,
                             input logic [2:0] cnt, input logic pr);
        check({tag, ".pop_valid"},  32'(bus.pop_valid),  32'(pv));
        check({tag, ".inst"},       32'(bus.inst),       32'(ins));
        check({tag, ".count"},      32'(bus.count),      32'(cnt));
        check({tag, ".push_ready"}, 32'(bus.push_ready), 32'(pr));
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset_n         = 1'b0;
        bus.flush       = 1'b0;
        bus.push_valid  = 1'b0;
        bus.push_inst   = '0;
        bus.pop_ready   = 1'b0;

        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        #1 check_out("reset", 1'b0, 16'hFFFF, 3'd0, 1'b1);

        // Two words, then an asynchronous reset in the middle of a cycle.
        bus.push_valid = 1'b1;
        bus.push_inst  = 16'h0AAA; cycle();
        bus.push_inst  = 16'h0BBB; cycle();
        bus.push_valid = 1'b0;
        check("pre_reset.count", 32'(bus.count), 32'd2);
        #2 reset_n = 1'b0;
        #1 check_out("async_reset", 1'b0, 16'hFFFF, 3'd0, 1'b1);
        cycle();
        reset_n = 1'b1;
        #1 check_out("after_reset", 1'b0, 16'hFFFF, 3'd0, 1'b1);

        // Fill to DEPTH with decode stalled, then try one extra push.
        for (int i = 0; i < DEPTH; i++) begin
            bus.push_valid = 1'b1;
            bus.push_inst  = 16'h1001 + 16'(i);
            cycle();
        end
        check_out("full", 1'b1, 16'h1001, 3'd4, 1'b0);
        bus.push_inst = 16'h1005;
        cycle();
        bus.push_valid = 1'b0;
        check_out("push_when_full", 1'b1, 16'h1001, 3'd4, 1'b0);

        bus.pop_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1 check("drain.inst", 32'(bus.inst), 32'h1001 + i);
            check("drain.pop_valid", 32'(bus.pop_valid), 32'd1);
            cycle();
        end
        check_out("drained", 1'b0, 16'hFFFF, 3'd0, 1'b1);
        cycle();
        check_out("pop_when_empty", 1'b0, 16'hFFFF, 3'd0, 1'b1);
        bus.pop_ready = 1'b0;

        // Simultaneous push/pop at count=2 across pointer wrap.
        bus.push_valid = 1'b1;
        bus.push_inst  = 16'h2000; cycle();
        bus.push_inst  = 16'h2001; cycle();
        bus.pop_ready  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.push_inst = 16'h2002 + 16'(i);
            #1 check("wrap.inst", 32'(bus.inst), 32'h2000 + i);
            check("wrap.count", 32'(bus.count), 32'd2);
            cycle();
        end
        bus.push_valid = 1'b0;
        #1 check("wrap_tail0", 32'(bus.inst), 32'h200A);
        cycle();
        check("wrap_tail1", 32'(bus.inst), 32'h200B);
        cycle();
        check_out("wrap_empty", 1'b0, 16'hFFFF, 3'd0, 1'b1);
        bus.pop_ready = 1'b0;

        // Flush with three entries and a coincident push.
        bus.push_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.push_inst = 16'h4001 + 16'(i);
            cycle();
        end
        check("pre_flush.count", 32'(bus.count), 32'd3);
        bus.flush     = 1'b1;
        bus.push_inst = 16'h2222;
        #1 check("flush.pop_valid", 32'(bus.pop_valid), 32'd0);
        check("flush.inst", 32'(bus.inst), 32'hFFFF);
        cycle();
        bus.flush      = 1'b0;
        bus.push_valid = 1'b0;
        #1 check_out("post_flush", 1'b0, 16'hFFFF, 3'd0, 1'b1);
        bus.push_valid = 1'b1;
        bus.push_inst  = 16'h5555;
        cycle();
        bus.push_valid = 1'b0;
        check_out("restart", 1'b1, 16'h5555, 3'd1, 1'b1);

        // Flush while full.
        bus.push_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.push_inst = 16'h6001 + 16'(i);
            cycle();
        end
        bus.push_valid = 1'b0;
        check("full2.push_ready", 32'(bus.push_ready), 32'd0);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        #1 check_out("flush_full", 1'b0, 16'hFFFF, 3'd0, 1'b1);

        // Backpressure: head stays stable while decode stalls.
        bus.push_valid = 1'b1;
        bus.push_inst  = 16'hABCD;
        cycle();
        bus.push_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 check_out("stall", 1'b1, 16'hABCD, 3'd1, 1'b1);
            cycle();
        end
        bus.pop_ready = 1'b1;
        cycle();
        check_out("stall_release", 1'b0, 16'hFFFF, 3'd0, 1'b1);

        // Push into an empty buffer with decode ready.
        bus.push_valid = 1'b1;
        bus.push_inst  = 16'h3333;
        #1;
`ifdef INST_BUFFER_BYPASS_EN
        check("bypass.inst", 32'(bus.inst), 32'h3333);
        check("bypass.pop_valid", 32'(bus.pop_valid), 32'd1);
        cycle();
        bus.push_valid = 1'b0;
        #1 check_out("bypass_after", 1'b0, 16'hFFFF, 3'd0, 1'b1);
`else
        check("nobypass.inst", 32'(bus.inst), 32'hFFFF);
        check("nobypass.pop_valid", 32'(bus.pop_valid), 32'd0);
        cycle();
        bus.push_valid = 1'b0;
        #1 check_out("nobypass_after", 1'b1, 16'h3333, 3'd1, 1'b1);
        cycle();
        check_out("nobypass_drain", 1'b0, 16'hFFFF, 3'd0, 1'b1);
`endif

        // Push into an empty buffer with decode stalled: always stored.
        bus.pop_ready  = 1'b0;
        bus.push_valid = 1'b1;
        bus.push_inst  = 16'h3434;
        #1;
`ifdef INST_BUFFER_BYPASS_EN
        check("bypass_stall.inst", 32'(bus.inst), 32'h3434);
`else
        check("nobypass_stall.inst", 32'(bus.inst), 32'hFFFF);
`endif
        cycle();
        bus.push_valid = 1'b0;
        #1 check_out("stall_store", 1'b1, 16'h3434, 3'd1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_inst_buffer
